// File: rtl/alu_seq_pkg.sv
// Shared constants, state encoding and flag-merge helper for the ALU
// sequencing controller.
package alu_seq_pkg;

    localparam int AW = 3;
    localparam int FW = 5;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_PASS1 = 3'b110;
    localparam logic [2:0] OP_PASS2 = 3'b111;

    localparam int F_Z  = 4;
    localparam int F_CY = 3;
    localparam int F_S  = 2;
    localparam int F_P  = 1;
    localparam int F_OV = 0;

    localparam int I_OP_LSB  = 13;
    localparam int I_CIN     = 12;
    localparam int I_RD_LSB  = 9;
    localparam int I_RS1_LSB = 6;
    localparam int I_RS2_LSB = 3;
    localparam int I_WR      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    // Only add/sub own CY; every other op leaves the old carry untouched.
    function automatic logic [FW-1:0] merge_flags(
        input logic [2:0]    op,
        input logic [FW-1:0] alu_f,
        input logic [FW-1:0] cur
    );
        logic [FW-1:0] m;
        m = alu_f;
        if (op != OP_ADD && op != OP_SUB) begin
            m[F_CY] = cur[F_CY];
        end
        return m;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x DW register file: two operand read ports, debug port, one write.
// ALU_SEQ_CTRL_ZERO_REG_EN hardwires r0 to zero.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] rd1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];
    logic          we_eff;

`ifdef ALU_SEQ_CTRL_ZERO_REG_EN
    assign we_eff   = we && (waddr != '0);
    assign rd1      = (ra1 == '0) ? '0 : mem_q[ra1];
    assign rd2      = (ra2 == '0) ? '0 : mem_q[ra2];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
`else
    assign we_eff   = we;
    assign rd1      = mem_q[ra1];
    assign rd2      = mem_q[ra2];
    assign dbg_data = mem_q[dbg_addr];
`endif

    always_comb begin
        mem_d = mem_q;
        if (we_eff) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Three-state sequencer (IDLE/EXEC/WB) driving an external combinational
// ALU; owns the register file and the {Z,CY,S,P,OV} flag register.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [2:0]    alu_opcode,
    output logic [DW-1:0] alu_arg1,
    output logic [DW-1:0] alu_arg2,
    output logic [FW-1:0] alu_in_flg,
    input  logic [DW-1:0] alu_res,
    input  logic [FW-1:0] alu_out_flg,
    output logic [FW-1:0] flags,
    output logic          done,
    input  logic [AW-1:0] rd_dbg_addr,
    output logic [DW-1:0] rd_dbg_data
);

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] arg1_q, arg1_d;
    logic [DW-1:0] arg2_q, arg2_d;
    logic [DW-1:0] res_q, res_d;
    logic [FW-1:0] in_flg_q, in_flg_d;
    logic [FW-1:0] oflg_q, oflg_d;
    logic [FW-1:0] flags_q, flags_d;

    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rs1_data, rs2_data;
    logic          unused_rsvd;

    assign unused_rsvd = ^instr[1:0];

    alu_seq_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .ra1      (instr[I_RS1_LSB +: AW]),
        .rd1      (rs1_data),
        .ra2      (instr[I_RS2_LSB +: AW]),
        .rd2      (rs2_data),
        .dbg_addr (rd_dbg_addr),
        .dbg_data (rd_dbg_data)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        arg1_d      = arg1_q;
        arg2_d      = arg2_q;
        res_d       = res_q;
        in_flg_d    = in_flg_q;
        oflg_d      = oflg_q;
        flags_d     = flags_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        we          = ld_en;
        waddr       = ld_addr;
        wdata       = ld_data;
        unique case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    op_d   = instr[I_OP_LSB +: 3];
                    rd_d   = instr[I_RD_LSB +: AW];
                    wr_d   = instr[I_WR];
                    arg1_d = rs1_data;
                    arg2_d = rs2_data;
                    in_flg_d = flags_q;
                    in_flg_d[F_CY] = flags_q[F_CY] & instr[I_CIN];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res;
                oflg_d  = alu_out_flg;
                state_d = WB;
            end
            WB: begin
                done    = 1'b1;
                flags_d = merge_flags(op_q, oflg_q, flags_q);
                // Writeback owns the single port; a same-cycle load loses.
                if (wr_q) begin
                    we    = 1'b1;
                    waddr = rd_q;
                    wdata = res_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            wr_q     <= 1'b0;
            arg1_q   <= '0;
            arg2_q   <= '0;
            res_q    <= '0;
            in_flg_q <= '0;
            oflg_q   <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            arg1_q   <= arg1_d;
            arg2_q   <= arg2_d;
            res_q    <= res_d;
            in_flg_q <= in_flg_d;
            oflg_q   <= oflg_d;
            flags_q  <= flags_d;
        end
    end

    assign alu_opcode = op_q;
    assign alu_arg1   = arg1_q;
    assign alu_arg2   = arg2_q;
    assign alu_in_flg = in_flg_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural ALU and a
// register/flag reference model.
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_CTRL_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_arg1;
    logic [15:0] alu_arg2;
    logic [4:0]  alu_in_flg;
    logic [15:0] alu_res;
    logic [4:0]  alu_out_flg;
    logic [4:0]  flags;
    logic        done;
    logic [2:0]  rd_dbg_addr;
    logic [15:0] rd_dbg_data;

    int nchk = 0;
    int nerr = 0;

    logic [15:0] mregs [8];
    logic [4:0]  mflags;

    typedef struct {
        logic        do_ld;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [2:0]  op;
        logic        cin;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        wr;
        logic [15:0] exp_rd;
        logic [4:0]  exp_flg;
        logic        exp_ci;
    } vec_t;

    vec_t tbl [7];

    alu_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_opcode  (alu_opcode),
        .alu_arg1    (alu_arg1),
        .alu_arg2    (alu_arg2),
        .alu_in_flg  (alu_in_flg),
        .alu_res     (alu_res),
        .alu_out_flg (alu_out_flg),
        .flags       (flags),
        .done        (done),
        .rd_dbg_addr (rd_dbg_addr),
        .rd_dbg_data (rd_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result {res, Z, CY, S, P(even), OV}; logic ops return a junk carry.
    function automatic logic [20:0] alu_fn(
        input logic [2:0]  op,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        ci
    );
        logic [16:0] w;
        logic [15:0] r;
        logic        cy;
        logic        ov;
        w  = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        r  = w[15:0];
        cy = ~a[0];
        ov = 1'b0;
        case (op)
            3'd0: begin
                cy = w[16];
                ov = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'd1: begin
                w  = {1'b0, a} - {1'b0, b} - {16'd0, ci};
                r  = w[15:0];
                cy = w[16];
                ov = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ~a;
            3'd6:    r = a;
            default: r = b;
        endcase
        return {r, (r == 16'd0), cy, r[15], ~^r, ov};
    endfunction

    logic [20:0] alu_o;
    always_comb alu_o = alu_fn(alu_opcode, alu_arg1, alu_arg2, alu_in_flg[3]);
    assign alu_res     = alu_o[20:5];
    assign alu_out_flg = alu_o[4:0];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mread(input logic [2:0] a);
        return (ZR && a == 3'd0) ? 16'd0 : mregs[a];
    endfunction

    task automatic mwrite(input logic [2:0] a, input logic [15:0] d);
        if (!(ZR && a == 3'd0)) mregs[a] = d;
    endtask

    task automatic mcommit(input logic [2:0] op, input logic [2:0] rd,
                           input logic wr, input logic [15:0] a,
                           input logic [15:0] b, input logic [4:0] inf);
        logic [20:0] r;
        r = alu_fn(op, a, b, inf[3]);
        if (wr) mwrite(rd, r[20:5]);
        if (op <= 3'd1) mflags = r[4:0];
        else            mflags = {r[4], mflags[3], r[2:0]};
    endtask

    function automatic logic [4:0] mcin(input logic cin);
        logic [4:0] f;
        f = mflags;
        f[3] = mflags[3] & cin;
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rdbg(input logic [2:0] a, output logic [15:0] d);
        rd_dbg_addr = a;
        #1;
        d = rd_dbg_data;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        ld_en = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
        mflags = 5'd0;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en = 1'b0;
        mwrite(a, d);
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op,
        input logic cin, input logic [2:0] rd, input logic [2:0] rs1,
        input logic [2:0] rs2, input logic wr);
        return {op, cin, rd, rs1, rs2, wr, 2'b00};
    endfunction

    // ldph: 0 none, 1 load during accept cycle, 2 load during WB cycle
    task automatic issue(input logic [2:0] op, input logic cin,
                         input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic wr,
                         input int ldph, input logic [2:0] la,
                         input logic [15:0] ldd);
        logic [15:0] a, b, d;
        logic [4:0]  inf;
        a   = mread(rs1);
        b   = mread(rs2);
        inf = mcin(cin);
        chk("ready_idle", instr_ready, 1);
        instr = mk(op, cin, rd, rs1, rs2, wr);
        instr_valid = 1'b1;
        if (ldph == 1) begin
            ld_en = 1'b1;
            ld_addr = la;
            ld_data = ldd;
        end
        step();
        instr_valid = 1'b0;
        ld_en = 1'b0;
        if (ldph == 1) mwrite(la, ldd);
        chk("exec_opcode", alu_opcode, op);
        chk("exec_arg1", alu_arg1, a);
        chk("exec_arg2", alu_arg2, b);
        chk("exec_in_flg", alu_in_flg, inf);
        chk("exec_done", done, 0);
        chk("exec_ready", instr_ready, 0);
        step();
        chk("wb_done", done, 1);
        chk("wb_ready", instr_ready, 0);
        chk("wb_arg1_hold", alu_arg1, a);
        if (ldph == 2) begin
            ld_en = 1'b1;
            ld_addr = la;
            ld_data = ldd;
        end
        step();
        ld_en = 1'b0;
        if (ldph == 2) mwrite(la, ldd);
        mcommit(op, rd, wr, a, b, inf);
        chk("post_done", done, 0);
        chk("post_ready", instr_ready, 1);
        chk("post_flags", flags, mflags);
        rdbg(rd, d);
        chk("post_rd", d, mread(rd));
    endtask

    task automatic chk_all_regs(input string nm);
        logic [15:0] d;
        for (int i = 0; i < 8; i++) begin
            rdbg(3'(i), d);
            chk(nm, d, mread(3'(i)));
        end
    endtask

    initial begin
        logic [15:0] d, a0;
        logic [4:0]  inf;
        int acc, dn;

        tbl[0] = '{1'b1, 16'h0003, 16'h0005, 3'd0, 1'b0, 3'd3, 3'd1,
                   3'd2, 1'b1, 16'h0008, 5'b00000, 1'b0};
        tbl[1] = '{1'b1, 16'hFFFF, 16'h0001, 3'd0, 1'b0, 3'd4, 3'd1,
                   3'd2, 1'b1, 16'h0000, 5'b11010, 1'b0};
        tbl[2] = '{1'b0, 16'h0000, 16'h0000, 3'd0, 1'b1, 3'd5, 3'd2,
                   3'd2, 1'b1, 16'h0003, 5'b00010, 1'b1};
        tbl[3] = '{1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 3'd7, 3'd1,
                   3'd2, 1'b1, 16'h0000, 5'b11010, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 16'h0000, 3'd4, 1'b0, 3'd6, 3'd1,
                   3'd1, 1'b1, 16'h0000, 5'b11010, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 16'h0000, 3'd2, 1'b1, 3'd7, 3'd1,
                   3'd2, 1'b1, 16'h0001, 5'b01000, 1'b1};
        tbl[6] = '{1'b0, 16'h0000, 16'h0000, 3'd1, 1'b0, 3'd1, 3'd1,
                   3'd1, 1'b0, 16'hFFFF, 5'b10010, 1'b0};

        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 16'd0;
        ld_en = 1'b0;
        ld_addr = 3'd0;
        ld_data = 16'd0;
        rd_dbg_addr = 3'd0;
        @(negedge clk);
        do_reset();

        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_flags", flags, 0);
        chk("rst_opcode", alu_opcode, 0);
        chk("rst_arg1", alu_arg1, 0);
        chk("rst_arg2", alu_arg2, 0);
        chk("rst_in_flg", alu_in_flg, 0);
        chk_all_regs("rst_reg");

        for (int k = 0; k < 7; k++) begin
            if (tbl[k].do_ld) begin
                load(3'd1, tbl[k].v1);
                load(3'd2, tbl[k].v2);
            end
            issue(tbl[k].op, tbl[k].cin, tbl[k].rd, tbl[k].rs1,
                  tbl[k].rs2, tbl[k].wr, 0, 3'd0, 16'd0);
            rdbg(tbl[k].rd, d);
            chk("tbl_rd", d, tbl[k].exp_rd);
            chk("tbl_flags", flags, tbl[k].exp_flg);
            chk("tbl_cin_idle", alu_in_flg[3], tbl[k].exp_ci);
        end
        chk_all_regs("tbl_regs");

        // Valid held high: one accept every third cycle.
        a0 = mread(3'd1);
        acc = 0;
        dn = 0;
        instr = mk(3'd1, 1'b0, 3'd1, 3'd1, 3'd1, 1'b0);
        instr_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (instr_ready && instr_valid) acc++;
            if (done) dn++;
            chk("held_ready", instr_ready, (c % 3 == 0) ? 1 : 0);
            step();
        end
        instr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inf = mcin(1'b0);
            mcommit(3'd1, 3'd1, 1'b0, a0, a0, inf);
        end
        chk("held_accepts", acc, 2);
        chk("held_dones", dn, 2);
        chk("held_flags", flags, mflags);
        chk_all_regs("held_regs");

        // Same-address load during WB loses to the writeback.
        do_reset();
        load(3'd1, 16'h1111);
        load(3'd2, 16'h2222);
        issue(3'd0, 1'b0, 3'd3, 3'd1, 3'd2, 1'b1, 2, 3'd3, 16'hAAAA);
        rdbg(3'd3, d);
        chk("wb_beats_ld", d, 16'h3333);
        // Load to rs1 in the accept cycle is not seen by that instruction.
        issue(3'd0, 1'b0, 3'd4, 3'd1, 3'd2, 1'b1, 1, 3'd1, 16'h0F0F);
        rdbg(3'd4, d);
        chk("accept_ld_unseen", d, 16'h3333);
        rdbg(3'd1, d);
        chk("accept_ld_lands", d, 16'h0F0F);
        // Load during WB of a compare goes through.
        issue(3'd1, 1'b0, 3'd5, 3'd1, 3'd1, 1'b0, 2, 3'd5, 16'h5A5A);
        rdbg(3'd5, d);
        chk("wb_nowr_ld", d, 16'h5A5A);

        // Reset while in EXEC aborts the instruction.
        instr = mk(3'd0, 1'b0, 3'd6, 3'd1, 3'd2, 1'b1);
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("abort_in_exec", instr_ready, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
        mflags = 5'd0;
        chk("abort_ready", instr_ready, 1);
        chk("abort_flags", flags, 0);
        chk("abort_arg1", alu_arg1, 0);
        step();
        step();
        chk("abort_no_done", done, 0);
        rdbg(3'd6, d);
        chk("abort_no_wb", d, 16'h0000);

        // r0 behaviour depends on the zero-register build option.
        load(3'd0, 16'h1234);
        rdbg(3'd0, d);
        chk("r0_load", d, ZR ? 16'h0000 : 16'h1234);
        issue(3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 0, 3'd0, 16'd0);
        rdbg(3'd0, d);
        chk("r0_add", d, ZR ? 16'h0000 : 16'h2468);

        // Randomized instructions against the reference model.
        do_reset();
        for (int i = 0; i < 8; i++) load(3'(i), 16'($urandom));
        for (int k = 0; k < 40; k++) begin
            logic [2:0] op, rd, rs1, rs2, la;
            logic       cin, wr;
            int         ph;
            op  = 3'($urandom_range(0, 7));
            rd  = 3'($urandom_range(0, 7));
            rs1 = 3'($urandom_range(0, 7));
            rs2 = 3'($urandom_range(0, 7));
            cin = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 3) != 0);
            ph  = $urandom_range(0, 2);
            la  = 3'($urandom_range(0, 7));
            if (ph == 2 && wr) la = rd;
            issue(op, cin, rd, rs1, rs2, wr, ph, la, 16'($urandom));
        end
        chk_all_regs("rand_regs");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing controller that acts as the initiator side of the combinational ALU interface. It accepts 16-bit register-register instructions over a valid/ready handshake and reads operands from an internal 8x16 register file. It drives the ALU's opcode, arg1, arg2 and in_flg inputs, then captures res and out_flg. It writes the result back, maintains the architectural flag register {Z,CY,S,P,OV}, and sits between the future fetch stage and the ALU.

Parameters:
- DW, 16, data and register width; must match the ALU operand width.
- NREG, 8, register count; the address width is 3.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept; high only in IDLE
- instr  in  16  [15:13] op, [12] cin_en, [11:9] rd, [8:6] rs1, [5:3] rs2, [2] wr_en, [1:0] reserved/ignored
- ld_en  in  1  direct register load (bench/boot)
- ld_addr  in  3  load address
- ld_data  in  16  load data
- alu_opcode  out  3  to ALU opcode
- alu_arg1  out  16  to ALU arg1
- alu_arg2  out  16  to ALU arg2
- alu_in_flg  out  5  to ALU in_flg; carries the current flag register, with CY forced to 0 when cin_en=0
- alu_res  in  16  from ALU res
- alu_out_flg  in  5  from ALU out_flg, {Z,CY,S,P,OV}
- flags  out  5  architectural flag register
- done  out  1  one-cycle pulse on instruction retire
- rd_dbg_addr  in  3  combinational debug read address
- rd_dbg_data  out  16  register-file contents at rd_dbg_addr

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; all registers=0; flags=0; done=0.
  - alu_opcode=0, alu_arg1=0, alu_arg2=0, alu_in_flg=0.
  - Reset mid-instruction aborts it: no writeback, no flag update.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid, latch instr, latch regs[rs1]->arg1 and regs[rs2]->arg2, latch the opcode, go to EXEC.
  - EXEC: ALU outputs settle combinationally. At the clock edge, capture alu_res and alu_out_flg, go to WB.
  - WB: if wr_en, regs[rd] <= captured res. flags <= merged flags. done=1. Go to IDLE.
- Latency and throughput: handshake in cycle N, done in cycle N+2, next accept in cycle N+3. Throughput is one instruction per 3 cycles.
- ALU outputs are registered and held stable from EXEC through WB. They retain their last values while in IDLE.
- Flag merge:
  - op 000/001 (add/sub): all five flags taken from the ALU.
  - op 010..111: Z, S, P, OV taken from the ALU; CY keeps its previous value. The ALU drives CY as X for these ops, and X must never reach the flags register.
- wr_en=0 (compare/test): flags update but no register write.
- Operand read uses register values as of the accept edge. rs1 and rs2 may be equal.
- ld_en:
  - Accepted in any state.
  - If a WB write targets the same address in the same cycle, the WB write wins.
  - A load to rs1/rs2 in the same cycle as accept is not seen by that instruction.
- Arithmetic is modulo 2^16. Overflow and carry are reported only via flags.
- rd_dbg_data reflects writes from the next cycle onward.

Optional Feature:
- Macro: ALU_SEQ_CTRL_ZERO_REG_EN.
- When defined, r0 is hardwired to 0: reads return 0, and writes from both WB and ld_en are discarded.
- When undefined, r0 is an ordinary register.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NOT=101, OP_PASS1=110, OP_PASS2=111;
  - flag indices Z=4, CY=3, S=2, P=1, OV=0;
  - instruction field bit positions;
  - the FSM state enum {IDLE, EXEC, WB}.
- One sub-module, alu_seq_regfile: NREG x DW storage with synchronous reset, two read ports plus a debug read port, and a single write port. The write port is arbitrated (WB over ld) in the parent.

Test Plan:
1. Reset, then load r1=0x0003, r2=0x0005; ADD r3=r1+r2, wr_en=1, cin_en=0 -> done at N+2; r3=0x0008; flags=5'b00000.
2. Load r1=0xFFFF, r2=0x0001; ADD r4 -> r4=0x0000, flags Z=1, CY=1. Then ADD r5=r2+r2 with cin_en=1 -> alu_in_flg[3]=1, r5=0x0003.
3. With CY=1, execute XOR r6=r1^r1 -> r6=0, Z=1, CY still 1 (never X); AND afterwards also keeps CY.
4. SUB r1-r1 with wr_en=0 -> no register change, Z=1; instr_valid held high through the instruction -> instr_ready low in EXEC/WB, exactly one accept per 3 cycles.
5. Same cycle as WB to r3: ld_en to r3 with data 0xAAAA -> r3 holds the WB result. Assert rst_n=0 during EXEC -> no writeback, flags=0, instr_ready=1 after release.
6. With ALU_SEQ_CTRL_ZERO_REG_EN: ld r0=0x1234, ADD r0=r0+r0 -> rd_dbg_data(r0)=0 throughout. Without the macro -> r0=0x2468.
